// File: rtl/vga_timing_gen_pkg.sv
// Shared types, the reference 640x480 mode and helpers used to size and place
// the raster regions of the VGA timing generator.
package vga_timing_gen_pkg;

    // One axis of a raster mode: visible span plus blanking pieces.
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    // A full mode: horizontal timing in pixels, vertical timing in lines.
    typedef struct packed {
        timing_t h;
        timing_t v;
    } mode_t;

    localparam mode_t VGA_640x480 = '{
        h: '{active: 32'd640, fp: 32'd16, sync: 32'd96, bp: 32'd48},
        v: '{active: 32'd480, fp: 32'd10, sync: 32'd2,  bp: 32'd33}
    };

    // Counts per line/frame: sync, back porch, active and front porch back to back.
    function automatic int unsigned span_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return sync + bp + active + fp;
    endfunction

    // First count of the active span (sync and back porch come before it).
    function automatic int unsigned active_first(input int unsigned sync,
                                                 input int unsigned bp);
        return sync + bp;
    endfunction

    // Last count of the active span.
    function automatic int unsigned active_last(input int unsigned sync,
                                                input int unsigned bp,
                                                input int unsigned active);
        return sync + bp + active - 32'd1;
    endfunction

    // Width of an active-area coordinate; never narrower than one bit.
    function automatic int unsigned pix_width(input int unsigned active);
        return (active > 32'd1) ? $clog2(active) : 32'd1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable in, sync/blanking/coordinates/strobes out.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10,
    parameter int PX_W  = 10,
    parameter int PY_W  = 9
) ();
    logic             pixEn;
    logic             hSync;
    logic             vSync;
    logic             vidOn;
    logic [CNT_W-1:0] hCounter;
    logic [CNT_W-1:0] vCounter;
    logic [PX_W-1:0]  pixX;
    logic [PY_W-1:0]  pixY;
    logic             lineStart;
    logic             frameStart;

    // Timing generator side.
    modport master (
        input  pixEn,
        output hSync, vSync, vidOn, hCounter, vCounter, pixX, pixY,
               lineStart, frameStart
    );

    // Pixel pipeline side.
    modport slave (
        output pixEn,
        input  hSync, vSync, vidOn, hCounter, vCounter, pixX, pixY,
               lineStart, frameStart
    );
endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Enabled modulo counter 0..MAX. Exposes the next count so the caller can
// decode registered outputs that line up with the count, and a wrap pulse
// for chaining the next axis.
module mod_counter #(
    parameter int          W   = 10,
    parameter int unsigned MAX = 32'd799
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step when enabled, return to zero after MAX, else hold.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (en) begin
            if (cnt_q == W'(MAX)) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. Two chained modulo counters track the
// beam; every output is decoded from the next count and registered alongside
// the counters, so all outputs describe the position shown in the same cycle.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640x480.h.active,
    parameter int unsigned H_FP     = VGA_640x480.h.fp,
    parameter int unsigned H_SYNC   = VGA_640x480.h.sync,
    parameter int unsigned H_BP     = VGA_640x480.h.bp,
    parameter int unsigned V_ACTIVE = VGA_640x480.v.active,
    parameter int unsigned V_FP     = VGA_640x480.v.fp,
    parameter int unsigned V_SYNC   = VGA_640x480.v.sync,
    parameter int unsigned V_BP     = VGA_640x480.v.bp,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int          CNT_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HA_FIRST = active_first(H_SYNC, H_BP);
    localparam int unsigned HA_LAST  = active_last(H_SYNC, H_BP, H_ACTIVE);
    localparam int unsigned VA_FIRST = active_first(V_SYNC, V_BP);
    localparam int unsigned VA_LAST  = active_last(V_SYNC, V_BP, V_ACTIVE);
    localparam int          PX_W     = int'(pix_width(H_ACTIVE));
    localparam int          PY_W     = int'(pix_width(V_ACTIVE));

    // Reject modes whose counts do not fit or that have empty blanking pieces.
    if (H_TOTAL > (32'd1 << CNT_W) || V_TOTAL > (32'd1 << CNT_W)) begin : g_chk_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if (H_FP < 32'd1 || H_SYNC < 32'd1 || H_BP < 32'd1 ||
        V_FP < 32'd1 || V_SYNC < 32'd1 || V_BP < 32'd1) begin : g_chk_porch
        $error("vga_timing_gen: porch and sync widths must be at least 1");
    end
    if ($bits(vga.pixX) != PX_W || $bits(vga.pixY) != PY_W ||
        $bits(vga.hCounter) != CNT_W) begin : g_chk_if
        $error("vga_timing_gen: interface widths do not match the mode");
    end

    logic [CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
    logic             h_wrap, v_wrap;

    mod_counter #(.W(CNT_W), .MAX(H_TOTAL - 32'd1)) u_h_cnt (
        .clk     (clk),
        .rst     (reset),
        .en      (vga.pixEn),
        .cnt     (h_cnt),
        .cnt_nxt (h_nxt),
        .wrap    (h_wrap)
    );

    // The line counter steps only on the edge where the pixel counter wraps.
    mod_counter #(.W(CNT_W), .MAX(V_TOTAL - 32'd1)) u_v_cnt (
        .clk     (clk),
        .rst     (reset),
        .en      (h_wrap),
        .cnt     (v_cnt),
        .cnt_nxt (v_nxt),
        .wrap    (v_wrap)
    );

    logic            hsync_d, hsync_q;
    logic            vsync_d, vsync_q;
    logic            vid_on_d, vid_on_q;
    logic [PX_W-1:0] pix_x_d, pix_x_q;
    logic [PY_W-1:0] pix_y_d, pix_y_q;
    logic            line_start_d, line_start_q;
    logic            frame_start_d, frame_start_q;
    logic            h_act_s, v_act_s;

    // Decode sync, blanking and coordinates from the count about to be loaded.
    always_comb begin
        hsync_d       = ~H_POL;
        vsync_d       = ~V_POL;
        vid_on_d      = 1'b0;
        pix_x_d       = '0;
        pix_y_d       = '0;
        h_act_s       = (h_nxt >= CNT_W'(HA_FIRST)) && (h_nxt <= CNT_W'(HA_LAST));
        v_act_s       = (v_nxt >= CNT_W'(VA_FIRST)) && (v_nxt <= CNT_W'(VA_LAST));
        // Strobes come only from a real wrap, so the reset state never fires them
        // and they fall again on the next clock whatever pixEn does.
        line_start_d  = h_wrap;
        frame_start_d = h_wrap & v_wrap;
        if (h_nxt < CNT_W'(H_SYNC)) begin
            hsync_d = H_POL;
        end else begin
            hsync_d = ~H_POL;
        end
        if (v_nxt < CNT_W'(V_SYNC)) begin
            vsync_d = V_POL;
        end else begin
            vsync_d = ~V_POL;
        end
        if (h_act_s && v_act_s) begin
            vid_on_d = 1'b1;
            pix_x_d  = PX_W'(h_nxt - CNT_W'(HA_FIRST));
            pix_y_d  = PY_W'(v_nxt - CNT_W'(VA_FIRST));
        end else begin
            vid_on_d = 1'b0;
            pix_x_d  = '0;
            pix_y_d  = '0;
        end
    end

    // Output registers; reset puts the beam at count 0, inside both sync pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q       <= H_POL;
            vsync_q       <= V_POL;
            vid_on_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vid_on_q      <= vid_on_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hSync      = hsync_q;
    assign vga.vSync      = vsync_q;
    assign vga.vidOn      = vid_on_q;
    assign vga.hCounter   = h_cnt;
    assign vga.vCounter   = v_cnt;
    assign vga.pixX       = pix_x_q;
    assign vga.pixY       = pix_y_q;
    assign vga.lineStart  = line_start_q;
    assign vga.frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (640x480 active-low, 640x480
// active-high, tiny 12x7 mode) share clock, reset and pixel enable. A
// behavioural raster model queues the expected outputs each cycle; a table of
// hand-computed points and a few explicit sequences cover the corners.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vid;
        logic [9:0] hc;
        logic [9:0] vc;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct {
        int   ht, vt, hs, hb, ha, vs, vb, va;
        logic hpol, vpol;
    } cfg_t;

    typedef struct {
        int   dut;
        int   h, v;
        logic hs, vs, vid;
        int   px, py;
        logic ls;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cfg_t cfg [3];
    int   m_h [3];
    int   m_v [3];
    out_t sb_q [$];
    out_t act [3];

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(10), .PX_W(10), .PY_W(9)) if_def ();
    vga_timing_gen_if #(.CNT_W(10), .PX_W(10), .PY_W(9)) if_pol ();
    vga_timing_gen_if #(.CNT_W(10), .PX_W(3),  .PY_W(2)) if_small ();

    assign if_def.pixEn   = pix_en;
    assign if_pol.pixEn   = pix_en;
    assign if_small.pixEn = pix_en;

    vga_timing_gen u_def (.clk(clk), .reset(rst), .vga(if_def));

    vga_timing_gen #(.H_POL(1'b1), .V_POL(1'b1)) u_pol (
        .clk(clk), .reset(rst), .vga(if_pol));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_small (
        .clk(clk), .reset(rst), .vga(if_small));

    assign act[0] = '{hs: if_def.hSync, vs: if_def.vSync, vid: if_def.vidOn,
                      hc: if_def.hCounter, vc: if_def.vCounter,
                      px: 10'(if_def.pixX), py: 10'(if_def.pixY),
                      ls: if_def.lineStart, fs: if_def.frameStart};
    assign act[1] = '{hs: if_pol.hSync, vs: if_pol.vSync, vid: if_pol.vidOn,
                      hc: if_pol.hCounter, vc: if_pol.vCounter,
                      px: 10'(if_pol.pixX), py: 10'(if_pol.pixY),
                      ls: if_pol.lineStart, fs: if_pol.frameStart};
    assign act[2] = '{hs: if_small.hSync, vs: if_small.vSync, vid: if_small.vidOn,
                      hc: if_small.hCounter, vc: if_small.vCounter,
                      px: 10'(if_small.pixX), py: 10'(if_small.pixY),
                      ls: if_small.lineStart, fs: if_small.frameStart};

    // Expected outputs for beam position (h, v) under mode c.
    function automatic out_t decode(input cfg_t c, input int h, input int v,
                                    input logic ls, input logic fs);
        out_t o;
        logic hact, vact;
        hact  = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.ha);
        vact  = (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.va);
        o.hc  = 10'(h);
        o.vc  = 10'(v);
        o.hs  = (h < c.hs) ? c.hpol : ~c.hpol;
        o.vs  = (v < c.vs) ? c.vpol : ~c.vpol;
        o.vid = hact && vact;
        o.px  = o.vid ? 10'(h - (c.hs + c.hb)) : 10'd0;
        o.py  = o.vid ? 10'(v - (c.vs + c.vb)) : 10'd0;
        o.ls  = ls;
        o.fs  = fs;
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %p expected %p", name, got, want);
        end
    endtask

    // One clock: drive enable/reset, queue the model prediction, compare after the edge.
    task automatic step(input logic en, input logic r);
        logic ls, fs;
        @(negedge clk);
        pix_en = en;
        rst    = r;
        for (int d = 0; d < 3; d++) begin
            ls = 1'b0;
            fs = 1'b0;
            if (r) begin
                m_h[d] = 0;
                m_v[d] = 0;
            end else if (en) begin
                if (m_h[d] == cfg[d].ht - 1) begin
                    m_h[d] = 0;
                    ls = 1'b1;
                    if (m_v[d] == cfg[d].vt - 1) begin
                        m_v[d] = 0;
                        fs = 1'b1;
                    end else begin
                        m_v[d] = m_v[d] + 1;
                    end
                end else begin
                    m_h[d] = m_h[d] + 1;
                end
            end
            sb_q.push_back(decode(cfg[d], m_h[d], m_v[d], ls, fs));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("sb dut%0d", d), act[d], sb_q.pop_front());
        end
    endtask

    // Run with pixEn high until the model of instance d sits at (h, v).
    task automatic run_to(input int d, input int h, input int v);
        int n = 0;
        while (!(m_h[d] == h && m_v[d] == v) && n < 60000) begin
            step(1'b1, 1'b0);
            n++;
        end
        if (n >= 60000) begin
            checks++;
            failures++;
            $display("FAIL run_to dut%0d: budget expired at (%0d,%0d), wanted (%0d,%0d)",
                     d, m_h[d], m_v[d], h, v);
        end
    endtask

    vec_t vecs [13];
    out_t want;
    int   max_py;
    int   fs_cnt;

    initial begin
        cfg[0] = '{ht: 800, vt: 525, hs: 96, hb: 48, ha: 640, vs: 2, vb: 33, va: 480,
                   hpol: 1'b0, vpol: 1'b0};
        cfg[1] = cfg[0];
        cfg[1].hpol = 1'b1;
        cfg[1].vpol = 1'b1;
        cfg[2] = '{ht: 12, vt: 7, hs: 2, hb: 1, ha: 8, vs: 1, vb: 1, va: 4,
                   hpol: 1'b0, vpol: 1'b0};

        //          dut  h    v   hs    vs    vid   px   py  ls
        vecs[0]  = '{1,  95,  0, 1'b1, 1'b1, 1'b0,   0, 0, 1'b0};
        vecs[1]  = '{0,  96,  0, 1'b1, 1'b0, 1'b0,   0, 0, 1'b0};
        vecs[2]  = '{1,  96,  0, 1'b0, 1'b1, 1'b0,   0, 0, 1'b0};
        vecs[3]  = '{0, 799,  0, 1'b1, 1'b0, 1'b0,   0, 0, 1'b0};
        vecs[4]  = '{0,   0,  1, 1'b0, 1'b0, 1'b0,   0, 0, 1'b1};
        vecs[5]  = '{1,   0,  1, 1'b1, 1'b1, 1'b0,   0, 0, 1'b1};
        vecs[6]  = '{1,   0,  2, 1'b1, 1'b0, 1'b0,   0, 0, 1'b1};
        vecs[7]  = '{0,   0,  2, 1'b0, 1'b1, 1'b0,   0, 0, 1'b1};
        vecs[8]  = '{0, 143, 35, 1'b1, 1'b1, 1'b0,   0, 0, 1'b0};
        vecs[9]  = '{0, 144, 35, 1'b1, 1'b1, 1'b1,   0, 0, 1'b0};
        vecs[10] = '{0, 783, 35, 1'b1, 1'b1, 1'b1, 639, 0, 1'b0};
        vecs[11] = '{0, 784, 35, 1'b1, 1'b1, 1'b0,   0, 0, 1'b0};
        vecs[12] = '{0, 200, 36, 1'b1, 1'b1, 1'b1,  56, 1, 1'b0};

        // Power-on reset held for two clocks.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        want = '{hs: 1'b0, vs: 1'b0, vid: 1'b0, hc: 10'd0, vc: 10'd0,
                 px: 10'd0, py: 10'd0, ls: 1'b0, fs: 1'b0};
        check("reset def", act[0], want);
        want.hs = 1'b1;
        want.vs = 1'b1;
        check("reset pol", act[1], want);

        // Hand-computed raster points on the 640x480 instances.
        foreach (vecs[i]) begin
            run_to(vecs[i].dut, vecs[i].h, vecs[i].v);
            want = '{hs: vecs[i].hs, vs: vecs[i].vs, vid: vecs[i].vid,
                     hc: 10'(vecs[i].h), vc: 10'(vecs[i].v),
                     px: 10'(vecs[i].px), py: 10'(vecs[i].py),
                     ls: vecs[i].ls, fs: 1'b0};
            check($sformatf("vec%0d", i), act[vecs[i].dut], want);
        end

        // Asynchronous reset mid-line at hCounter=300.
        run_to(0, 300, 36);
        @(negedge clk);
        rst = 1'b1;
        #1;
        want = '{hs: 1'b0, vs: 1'b0, vid: 1'b0, hc: 10'd0, vc: 10'd0,
                 px: 10'd0, py: 10'd0, ls: 1'b0, fs: 1'b0};
        check("async reset def", act[0], want);
        check("async reset small", act[2], want);
        step(1'b1, 1'b1);
        check("reset held def", act[0], want);

        // First enable after release moves to hCounter=1 with no strobe.
        step(1'b1, 1'b0);
        want.hc = 10'd1;
        check("first pixEn def", act[0], want);

        // Enable one clock in four: steps every fourth clock, strobes stay one clock.
        for (int i = 0; i < 400; i++) begin
            step((i % 4) == 0, 1'b0);
        end

        // Tiny mode: arrive at a frame start, then trace one full frame.
        step(1'b1, 1'b0);
        run_to(2, 0, 0);
        checks++;
        if (act[2].fs !== 1'b1) begin
            failures++;
            $display("FAIL small frameStart: got %b expected 1", act[2].fs);
        end
        max_py = 0;
        fs_cnt = 0;
        for (int i = 0; i < 84; i++) begin
            step(1'b1, 1'b0);
            if (int'(act[2].py) > max_py) max_py = int'(act[2].py);
            if (act[2].fs === 1'b1) fs_cnt++;
        end
        checks++;
        if (max_py != 3) begin
            failures++;
            $display("FAIL small pixY max: got %0d expected 3", max_py);
        end
        checks++;
        if (fs_cnt != 1) begin
            failures++;
            $display("FAIL small frame strobes: got %0d expected 1", fs_cnt);
        end

        // Idle clocks after the run: strobes must drop and levels hold.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
